pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the stall[5:0] vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences exception/ERET entry: it detects the exception in MEM, issues a one-cycle flush with a redirect PC, and holds off re-entry until the refetch is accepted. It also runs a stall watchdog.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions except ERET
STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog flags
CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > STALL_TIMEOUT

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stallreq_if  in  1  instruction SRAM not ready
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle ALU (div/madd) busy
stallreq_mem  in  1  data SRAM not ready
excepttype_i  in  32  exception code of the instruction in MEM; 0 = none
cp0_epc_i  in  32  current CP0 EPC
stall  out  6  [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb, [5]=wb
flush  out  1  flush all pipeline registers
new_pc  out  32  redirect target; valid while flush=1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=IDLE, flush=0, new_pc=0, stall_timeout=0, watchdog counter=0. Stall is combinational, so it evaluates to 0 while in reset.
- Stall encoding is combinational with fixed priority: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
- FSM states: IDLE, FLUSH, REFILL.
- IDLE, with excepttype_i != 0 and stallreq_mem == 0 (detect cycle):
  - stall is forced to 6'b011111, so MEM/WB takes a bubble and the excepting instruction does not write back.
  - On the next clock: state <= FLUSH; flush <= 1.
  - new_pc <= cp0_epc_i if excepttype_i == EXC_ERET, else EXC_VECTOR.
- IDLE, with excepttype_i != 0 and stallreq_mem == 1: normal mem stall; the exception stays pending. MEM is frozen, so the code persists.
- Exception together with stallreq_ex, stallreq_id or stallreq_if: the exception wins. Younger stages are flushed next cycle anyway.
- FLUSH lasts exactly one cycle: flush=1, stall=0 (flush dominates in the registers). Next state is REFILL, and flush <= 0. new_pc holds its value.
- REFILL: excepttype_i is ignored and stall follows the normal priority. Transition to IDLE on the first cycle with stallreq_if == 0, i.e. the vector fetch is accepted.
- Watchdog:
  - The counter increments on every cycle with stall != 0 and clears on any cycle with stall == 0.
  - It saturates at STALL_TIMEOUT.
  - When it reaches STALL_TIMEOUT, stall_timeout is set and stays set until reset.
- Reset mid-FLUSH or mid-REFILL: immediate return to the reset values; no flush is completed.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with stall != 0) and perf_flush_cnt[31:0] (FLUSH entries). Both are free-running wrap-around counters, reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared defines: stall encodings, EXC_* codes (INT 0x1, ADEL 0x4, ADES 0x5, SYSCALL 0x8, BREAK 0x9, RI 0xa, OV 0xc, TRAP 0xd, ERET 0xe), FSM state encodings, EXC_VECTOR default.
- Sub-module: stall_watchdog (the counter and sticky flag) is natural; everything else stays in pipe_ctrl.

Test Plan:
- Each stallreq_* raised alone for 3 cycles -> stall = 011111 / 001111 / 000111 / 000011 respectively; with all four raised -> 011111.
- excepttype_i = 0x8 for one cycle, no stalls -> detect cycle stall = 011111; next cycle flush = 1 and new_pc = 0xBFC00380; following cycle flush = 0, state REFILL.
- excepttype_i = 0xe with cp0_epc_i = 0x80001234 -> flush pulse with new_pc = 0x80001234.
- excepttype_i = 0xc together with stallreq_mem = 1 for 4 cycles -> stall = 011111 and flush = 0 throughout; flush asserts the cycle after stallreq_mem drops.
- STALL_TIMEOUT = 8, stallreq_ex held for 10 cycles -> stall_timeout rises after the 8th stalled cycle and stays 1 after the stall clears; rst pulsed low asynchronously mid-REFILL -> all outputs 0 immediately.
- With PIPE_CTRL_PERF_EN: 5 stalled cycles and 2 exceptions -> perf_stall_cycles = 5 + 2 detect cycles = 7 (assuming no other stalls), perf_flush_cnt = 2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings,
// exception codes, FSM states and the default exception vector.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_ADEL    = 32'h4;
  localparam logic [31:0] EXC_ADES    = 32'h5;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_BREAK   = 32'h9;
  localparam logic [31:0] EXC_RI      = 32'ha;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } pipe_state_e;

  // Fixed-priority merge of per-stage stall requests (oldest stage wins).
  function automatic logic [5:0] stall_encode(input logic mem, input logic ex,
                                              input logic id, input logic fe);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else if (fe) return STALL_IF;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the core datapath (master) and the
// controller (slave). Performance counter outputs exist only when
// PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cycles, perf_flush_cnt
`endif
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cycles, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating) and raises
// a sticky flag once the count reaches STALL_TIMEOUT.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall_active,
  output logic o_timeout
);
  localparam logic [CNT_W-1:0] LIM    = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  // Consecutive-stall counter, saturating at the limit; sticky flag set on the
  // edge where the count reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (!i_stall_active)  r_cnt <= '0;
      else if (r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
      if (i_stall_active && (r_cnt >= LIM_M1)) r_flag <= 1'b1;
    end
  end

  assign o_timeout = r_flag;
endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merging, exception/ERET flush
// sequencing and stall watchdog. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  ctrl
);
  pipe_state_e r_state, w_state_n;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [5:0]  w_stall;
  logic        w_detect;
  logic        w_timeout;

  // Next state and stall vector; stall is forced idle while in reset.
  always_comb begin
    w_state_n = r_state;
    w_detect  = 1'b0;
    w_stall   = stall_encode(ctrl.stallreq_mem, ctrl.stallreq_ex,
                             ctrl.stallreq_id, ctrl.stallreq_if);
    unique case (r_state)
      ST_IDLE: begin
        // A mem stall freezes MEM, so the exception simply stays pending.
        if ((ctrl.excepttype_i != EXC_NONE) && !ctrl.stallreq_mem) begin
          w_detect  = 1'b1;
          w_stall   = STALL_MEM;
          w_state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_stall   = STALL_NONE;
        w_state_n = ST_REFILL;
      end
      ST_REFILL: begin
        if (!ctrl.stallreq_if) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (!rst) w_stall = STALL_NONE;
  end

  // State register, flush pulse and redirect target capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else begin
      r_state <= w_state_n;
      r_flush <= w_detect;
      if (w_detect)
        r_new_pc <= (ctrl.excepttype_i == EXC_ERET) ? ctrl.cp0_epc_i : EXC_VECTOR;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .i_stall_active (w_stall != STALL_NONE),
    .o_timeout      (w_timeout)
  );

  assign ctrl.stall         = w_stall;
  assign ctrl.flush         = r_flush;
  assign ctrl.new_pc        = r_new_pc;
  assign ctrl.stall_timeout = w_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Free-running stalled-cycle and flush-entry counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall != STALL_NONE) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_detect)              r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign ctrl.perf_stall_cycles = r_perf_stall;
  assign ctrl.perf_flush_cnt    = r_perf_flush;
`endif
endmodule
